// File: rtl/timer_pkg.sv
// timer_pkg: shared state encodings, divider defaults and event helpers for the mm:ss timer sequencer
package timer_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SET      = 3'd1;
  localparam logic [2:0] ST_RUN_UP   = 3'd2;
  localparam logic [2:0] ST_RUN_DOWN = 3'd3;
  localparam logic [2:0] ST_PAUSED   = 3'd4;
  localparam logic [2:0] ST_EXPIRED  = 3'd5;

  localparam int TICK_DIV_DEFAULT  = 50_000_000;
  localparam int BLINK_DIV_DEFAULT = 12_500_000;
  localparam int SIM_TICK_DIV      = 10;
  localparam int SIM_BLINK_DIV     = 4;

  typedef struct packed {
    logic del;
    logic stop;
    logic start;
    logic inc_sec;
    logic inc_min;
  } btn_ev_t;

  // Keep only the highest-priority event(s) of a cycle: delete > stop > start > increment.
  function automatic btn_ev_t prioritize(input btn_ev_t r);
    btn_ev_t p;
    p.del     = r.del;
    p.stop    = r.stop & ~r.del;
    p.start   = r.start & ~r.stop & ~r.del;
    p.inc_sec = r.inc_sec & ~(r.start | r.stop | r.del);
    p.inc_min = r.inc_min & ~(r.start | r.stop | r.del);
    return p;
  endfunction

  // Count direction shown to the counter for a given state; PAUSED remembers the run it came from.
  function automatic logic fwd_for(input logic [2:0] st, input logic dir_up);
    return (st == ST_PAUSED) ? dir_up : !(st == ST_RUN_DOWN || st == ST_EXPIRED);
  endfunction

endpackage

// File: rtl/button_edge_sync.sv
// button_edge_sync: 2-FF synchronizer followed by a registered rising-edge pulse
module button_edge_sync (
  input  logic CLK_50MHZ,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic [2:0] sh;

  // Chain resets to all ones so a button already held at reset release is not seen as a new press.
  always_ff @(posedge CLK_50MHZ or posedge reset)
    if (reset) begin
      sh   <= '1;
      rise <= 1'b0;
    end else begin
      sh   <= {sh[1:0], btn};
      rise <= sh[1] & ~sh[2];
    end

endmodule

// File: rtl/timer_run_controller.sv
// timer_run_controller: button conditioning, run/set/expire sequencing and count strobe for the mm:ss timer
module timer_run_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic       CLK_50MHZ,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       delete,
  input  logic       incrementSeconds,
  input  logic       incrementMinutes,
  input  logic       zero,
  output logic       enableCounter,
  output logic       forward,
  output logic       resetTimer,
  output logic       incSecPulse,
  output logic       incMinPulse,
  output logic       alarm,
  output logic       blink,
  output logic [2:0] state
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  btn_ev_t ev_raw, ev;
  logic [2:0] state_d;
  logic [TW-1:0] presc;
  logic [BW-1:0] bcnt;
  logic dir_up, dir_up_d, clear_d, isec_d, imin_d, run_hold, exp_hold;

  button_edge_sync u_del   (.CLK_50MHZ(CLK_50MHZ), .reset(reset), .btn(delete),           .rise(ev_raw.del));
  button_edge_sync u_stop  (.CLK_50MHZ(CLK_50MHZ), .reset(reset), .btn(stop),             .rise(ev_raw.stop));
  button_edge_sync u_start (.CLK_50MHZ(CLK_50MHZ), .reset(reset), .btn(start),            .rise(ev_raw.start));
  button_edge_sync u_isec  (.CLK_50MHZ(CLK_50MHZ), .reset(reset), .btn(incrementSeconds), .rise(ev_raw.inc_sec));
  button_edge_sync u_imin  (.CLK_50MHZ(CLK_50MHZ), .reset(reset), .btn(incrementMinutes), .rise(ev_raw.inc_min));

  assign ev       = prioritize(ev_raw);
  assign run_hold = (state == ST_RUN_UP || state == ST_RUN_DOWN) && state_d == state;
  assign exp_hold = state == ST_EXPIRED && state_d == ST_EXPIRED;

  // Next state, saved direction and the pulses that accompany each transition.
  always_comb begin
    state_d  = state;
    dir_up_d = dir_up;
    clear_d  = 1'b0;
    isec_d   = 1'b0;
    imin_d   = 1'b0;
    case (state)
      ST_IDLE:
        if (ev.del) clear_d = 1'b1;
        else if (ev.start) begin
          state_d  = ST_RUN_UP;
          dir_up_d = 1'b1;
        end else if (ev.inc_sec | ev.inc_min) begin
          state_d = ST_SET;
          isec_d  = ev.inc_sec;
          imin_d  = ev.inc_min;
        end
      ST_SET:
        if (ev.del) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (ev.start) begin
          state_d  = zero ? ST_RUN_UP : ST_RUN_DOWN;
          dir_up_d = zero;
        end else begin
          isec_d = ev.inc_sec;
          imin_d = ev.inc_min;
        end
      ST_RUN_UP, ST_RUN_DOWN:
        if (ev.del) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (ev.stop) state_d = ST_PAUSED;
        else if (state == ST_RUN_DOWN && zero) state_d = ST_EXPIRED;
      ST_PAUSED:
        if (ev.del) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (ev.start) state_d = dir_up ? ST_RUN_UP : ST_RUN_DOWN;
      ST_EXPIRED:
        if (ev.del | ev.stop) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and registered one-cycle control outputs.
  always_ff @(posedge CLK_50MHZ or posedge reset)
    if (reset) begin
      state       <= ST_IDLE;
      dir_up      <= 1'b0;
      forward     <= 1'b1;
      resetTimer  <= 1'b0;
      incSecPulse <= 1'b0;
      incMinPulse <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      state       <= state_d;
      dir_up      <= dir_up_d;
      forward     <= fwd_for(state_d, dir_up_d);
      resetTimer  <= clear_d;
      incSecPulse <= isec_d;
      incMinPulse <= imin_d;
      alarm       <= state_d == ST_EXPIRED;
    end

  // Prescaler: counts only while staying in a RUN state, holds through PAUSED, otherwise restarts from 0.
  always_ff @(posedge CLK_50MHZ or posedge reset)
    if (reset) begin
      presc         <= '0;
      enableCounter <= 1'b0;
    end else begin
      presc         <= run_hold ? (presc == TICK_LAST ? '0 : presc + 1'b1) : (state_d == ST_PAUSED ? presc : '0);
      enableCounter <= run_hold && presc == TICK_LAST;
    end

  // Blink flag: set on entry to EXPIRED, toggled every BLINK_DIV cycles, cleared on exit.
  always_ff @(posedge CLK_50MHZ or posedge reset)
    if (reset) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else begin
      bcnt  <= exp_hold ? (bcnt == BLINK_LAST ? '0 : bcnt + 1'b1) : '0;
      blink <= exp_hold ? (bcnt == BLINK_LAST ? ~blink : blink) : state_d == ST_EXPIRED;
    end

endmodule

// File: tb/tb_timer_run_controller.sv
// tb_timer_run_controller: directed sequence with a pulse scoreboard for timer_run_controller
module tb_timer_run_controller;
  import timer_pkg::*;

  logic CLK_50MHZ = 1'b0;
  logic reset = 1'b0, start = 1'b0, stop = 1'b0, delete = 1'b0;
  logic incrementSeconds = 1'b0, incrementMinutes = 1'b0, zero = 1'b0;
  logic enableCounter, forward, resetTimer, incSecPulse, incMinPulse, alarm, blink;
  logic [2:0] state;
  int checks = 0, failures = 0, cyc = 0, n;
  logic [35:0] sb[$];
  logic [8:0] pat;

  localparam logic [3:0] K_ENA = 4'b1000, K_RST = 4'b0100, K_SEC = 4'b0010, K_MIN = 4'b0001;

  timer_run_controller #(.TICK_DIV(SIM_TICK_DIV), .BLINK_DIV(SIM_BLINK_DIV)) dut (
    .CLK_50MHZ(CLK_50MHZ), .reset(reset), .start(start), .stop(stop), .delete(delete),
    .incrementSeconds(incrementSeconds), .incrementMinutes(incrementMinutes), .zero(zero),
    .enableCounter(enableCounter), .forward(forward), .resetTimer(resetTimer),
    .incSecPulse(incSecPulse), .incMinPulse(incMinPulse), .alarm(alarm), .blink(blink), .state(state)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance k falling edges; every pulse seen must match the oldest scoreboard entry (kind and cycle).
  task automatic tick(input int k);
    logic [35:0] e;
    repeat (k) begin
      @(negedge CLK_50MHZ);
      cyc++;
      if (enableCounter | resetTimer | incSecPulse | incMinPulse) begin
        e = (sb.size() != 0) ? sb.pop_front() : '1;
        chk("pulse", {enableCounter, resetTimer, incSecPulse, incMinPulse, 32'(cyc)}, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("rst_state", 36'(state), 36'(ST_IDLE));
    chk("rst_fwd", 36'(forward), 36'd1);
    chk("rst_outs", 36'({enableCounter, resetTimer, incSecPulse, incMinPulse, alarm, blink}), 36'd0);
    tick(6);
    chk("held_start_ignored", 36'(state), 36'(ST_IDLE));
    start = 1'b0;
    tick(3);

    sb.push_back({K_MIN, 32'(cyc + 4)});
    incrementMinutes = 1'b1;
    tick(5);
    chk("idle_to_set", 36'(state), 36'(ST_SET));
    incrementMinutes = 1'b0;
    tick(3);
    sb.push_back({K_MIN, 32'(cyc + 4)});
    incrementMinutes = 1'b1;
    tick(5);
    incrementMinutes = 1'b0;
    tick(3);
    sb.push_back({K_SEC, 32'(cyc + 4)});
    incrementSeconds = 1'b1;
    tick(5);
    incrementSeconds = 1'b0;
    tick(3);
    chk("set_state", 36'(state), 36'(ST_SET));
    chk("set_fwd", 36'(forward), 36'd1);

    zero = 1'b0;
    n = cyc;
    sb.push_back({K_ENA, 32'(n + 14)});
    sb.push_back({K_ENA, 32'(n + 24)});
    start = 1'b1;
    tick(3);
    chk("start_latency", 36'(state), 36'(ST_SET));
    tick(1);
    chk("run_down_state", 36'(state), 36'(ST_RUN_DOWN));
    chk("run_down_fwd", 36'(forward), 36'd0);
    start = 1'b0;
    tick(25);

    zero = 1'b1;
    tick(1);
    chk("expired_state", 36'(state), 36'(ST_EXPIRED));
    chk("expired_alarm", 36'(alarm), 36'd1);
    chk("expired_fwd", 36'(forward), 36'd0);
    pat = 9'b1_0000_1111;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("blink%0d", i), 36'(blink), 36'(pat[i]));
      tick(1);
    end
    sb.push_back({K_RST, 32'(cyc + 4)});
    stop = 1'b1;
    tick(4);
    chk("stop_exp_state", 36'(state), 36'(ST_IDLE));
    chk("stop_exp_alarm_blink", 36'({alarm, blink}), 36'd0);
    chk("stop_exp_fwd", 36'(forward), 36'd1);
    stop = 1'b0;
    zero = 1'b0;
    tick(4);

    n = cyc;
    sb.push_back({K_ENA, 32'(n + 14)});
    start = 1'b1;
    tick(4);
    chk("run_up_state", 36'(state), 36'(ST_RUN_UP));
    chk("run_up_fwd", 36'(forward), 36'd1);
    start = 1'b0;
    tick(13);
    stop = 1'b1;
    tick(4);
    chk("paused_state", 36'(state), 36'(ST_PAUSED));
    chk("paused_fwd", 36'(forward), 36'd1);
    stop = 1'b0;
    tick(20);
    chk("paused_no_strobe", 36'(sb.size()), 36'd0);
    n = cyc;
    sb.push_back({K_ENA, 32'(n + 14)});
    start = 1'b1;
    tick(4);
    chk("resume_state", 36'(state), 36'(ST_RUN_UP));
    chk("resume_fwd", 36'(forward), 36'd1);
    start = 1'b0;
    tick(10);
    chk("resume_strobe_seen", 36'(sb.size()), 36'd0);
    stop = 1'b1;
    tick(4);
    chk("paused_again", 36'(state), 36'(ST_PAUSED));
    stop = 1'b0;
    tick(4);

    sb.push_back({K_RST, 32'(cyc + 4)});
    delete = 1'b1;
    start = 1'b1;
    tick(4);
    chk("del_beats_start", 36'(state), 36'(ST_IDLE));
    delete = 1'b0;
    start = 1'b0;
    tick(15);
    chk("start_dropped", 36'(state), 36'(ST_IDLE));

    sb.push_back({K_RST, 32'(cyc + 4)});
    delete = 1'b1;
    tick(4);
    chk("idle_delete", 36'(state), 36'(ST_IDLE));
    delete = 1'b0;
    tick(3);

    start = 1'b1;
    tick(4);
    chk("pre_reset_run", 36'(state), 36'(ST_RUN_UP));
    start = 1'b0;
    tick(3);
    #3 reset = 1'b1;
    #1;
    chk("async_rst", 36'({state, forward, enableCounter, resetTimer, incSecPulse, incMinPulse, alarm, blink}),
        36'({ST_IDLE, 1'b1, 6'd0}));
    tick(2);
    reset = 1'b0;
    tick(12);
    chk("after_rst_idle", 36'(state), 36'(ST_IDLE));
    chk("sb_drained", 36'(sb.size()), 36'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_run_controller.md
Name: timer_run_controller

Overview:
- Sequencer for the mm:ss timer datapath: BCD minutes/seconds counter plus VGA digit painter.
- Conditions raw button levels and generates the 1 Hz count strobe.
- Decides count direction, clear and manual-set pulses.
- Runs the expiry alarm, whose blink flag the painter uses to flash the digits. Sits between the board buttons and the counter at top level.

Parameters:
- TICK_DIV, 50000000: CLK_50MHZ cycles per count strobe (1 s).
- BLINK_DIV, 12500000: CLK_50MHZ cycles per blink toggle while expired.

Ports:
- CLK_50MHZ  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  raw button level.
- stop  input  1  raw button level.
- delete  input  1  raw button level.
- incrementSeconds  input  1  raw button level.
- incrementMinutes  input  1  raw button level.
- zero  input  1  counter reads 00:00 (registered by the counter).
- enableCounter  output  1  one-cycle count strobe.
- forward  output  1  1 = count up, 0 = count down.
- resetTimer  output  1  one-cycle synchronous clear to the counter.
- incSecPulse  output  1  one-cycle +1 s set pulse.
- incMinPulse  output  1  one-cycle +1 min set pulse.
- alarm  output  1  high while EXPIRED.
- blink  output  1  digit-blank flag for the painter.
- state  output  3  current state encoding, for debug.

Behaviour:
- Reset values: state=IDLE; all outputs 0 except forward=1. Prescaler, blink counter and saved direction are cleared.
- Input conditioning: each button passes through a 2-FF synchronizer, then a rising-edge detector. A raw rise sampled at edge k yields a one-cycle event at edge k+2. The state reacts at edge k+3. Held buttons produce exactly one event.
- Event priority within one cycle: delete > stop > start > increment. Lower-priority events in the same cycle are dropped.
- IDLE (0):
  - start → RUN_UP, dir=up.
  - increment event → SET, forwarded as a pulse the same cycle the event is seen.
  - delete → resetTimer pulse, stay in IDLE.
- SET (1):
  - Increment events forwarded as incSecPulse/incMinPulse.
  - start → RUN_DOWN (dir=down) if zero=0, else RUN_UP (dir=up).
  - delete → IDLE with resetTimer pulse.
- RUN_UP (2) / RUN_DOWN (3):
  - Prescaler counts 0..TICK_DIV-1.
  - enableCounter pulses for one cycle when it reaches TICK_DIV-1, then it wraps to 0.
  - The prescaler is cleared on every entry to a RUN state, so the first strobe comes exactly TICK_DIV cycles after the transition edge.
  - Increment events are ignored.
  - stop → PAUSED; the prescaler value is held.
  - delete → IDLE with resetTimer.
- RUN_DOWN expiry: zero=1 → EXPIRED on the next edge. No strobe is issued in a cycle where zero=1.
- RUN_UP ignores zero; the counter's 99:59 → 00:00 wrap is allowed.
- PAUSED (4):
  - start → resume the saved direction with the prescaler cleared.
  - delete → IDLE with resetTimer.
  - Increment events are ignored.
- EXPIRED (5):
  - alarm=1. blink toggles every BLINK_DIV cycles, starting at 1 on entry.
  - stop or delete → IDLE with resetTimer; alarm and blink drop to 0 on that edge.
  - start is ignored.
- forward is registered: up in IDLE/SET and RUN_UP, the saved direction in PAUSED, down in RUN_DOWN/EXPIRED.
- Output pulses are registered and never wider than one cycle.
- Encodings 6 and 7 are unreachable; if entered, go to IDLE next edge.
- Reset mid-RUN: all outputs go to reset values immediately (asynchronously). Operation resumes in IDLE after release.

Decomposition:
- Shared package `timer_pkg`: 3-bit state encodings, default TICK_DIV and BLINK_DIV, simulation divider constants.
- One natural sub-module, `button_edge_sync` (2-FF synchronizer + rising-edge pulse), instantiated five times.

Test Plan (TICK_DIV=10, BLINK_DIV=4):
- Reset held 3 cycles, then released → state=0, forward=1, all pulses 0, with no spurious events from buttons already held high at release.
- In IDLE, pulse incrementMinutes twice then incrementSeconds once → exactly 2 incMinPulse and 1 incSecPulse, each one cycle wide; state=1.
- From SET with zero=0, press start → state=3 at raw-rise+3 edges, forward=0; enableCounter pulses every 10 cycles, first 10 cycles after entry.
- In RUN_DOWN, drive zero=1 → no further enableCounter; next edge state=5, alarm=1; blink sequence 1,1,1,1,0,0,0,0,1…; stop → state=0, resetTimer one cycle, alarm=0.
- In RUN_UP, press stop at prescaler=6 → PAUSED with no strobes; press start → RUN_UP, forward=1, next strobe 10 cycles later.
- delete and start rising in the same cycle during PAUSED → IDLE plus resetTimer; start is dropped (no RUN entry).
